// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the execute stage.
// Fixed-latency MULT/MULTU/DIV/DIVU plus MTHI/MTLO; busy/stall_req freeze issue while an op is in flight.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             busy_q, busy_d;

    logic [63:0]        prod;
    logic [31:0]        quo;
    logic [31:0]        rem;
    logic [31:0]        b_safe;
    logic signed [31:0] sa;
    logic signed [31:0] sb;

    // Datapath from latched operands; divisor forced non-zero so /0 never reaches the operator.
    always_comb begin
        prod   = 64'd0;
        quo    = 32'd0;
        rem    = 32'd0;
        b_safe = (b_q == 32'd0) ? 32'd1 : b_q;
        sa     = $signed(a_q);
        sb     = $signed(b_safe);
        if (op_q == OP_MULT) begin
            prod = 64'($signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q}));
        end else begin
            prod = 64'({32'd0, a_q} * {32'd0, b_q});
        end
        if (op_q == OP_DIV) begin
            if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
                quo = 32'h8000_0000;
                rem = 32'd0;
            end else begin
                quo = 32'(sa / sb);
                rem = 32'(sa % sb);
            end
        end else begin
            quo = a_q / b_safe;
            rem = a_q % b_safe;
        end
    end

    // Next-state and register update logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (md_op)
                        OP_MULT, OP_MULTU: begin
                            state_d = ST_MULT;
                            cnt_d   = CNT_W'(MULT_CYCLES - 1);
                            op_d    = md_op;
                            a_d     = rs_val;
                            b_d     = rt_val;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = ST_DIV;
                            cnt_d   = CNT_W'(DIV_CYCLES - 1);
                            op_d    = md_op;
                            a_d     = rs_val;
                            b_d     = rt_val;
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            ST_MULT: begin
                if (cnt_q == CNT_W'(0)) begin
                    state_d = ST_IDLE;
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DIV: begin
                if (cnt_q == CNT_W'(0)) begin
                    state_d = ST_IDLE;
                    if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;
    assign stall_req = busy_q | (start & (md_op >= OP_MULT) & (md_op <= OP_DIVU));

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: vector table of single ops plus hand-written multi-cycle sequences.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_checks;
    int n_fail;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .busy      (busy),
        .stall_req (stall_req),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        logic        stall;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op on the next rising edge; returns after that edge with start dropped and operands scrambled.
    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic exp_stall, input string name);
        @(negedge clk);
        start  = 1'b1;
        md_op  = op;
        rs_val = rs;
        rt_val = rt;
        #1;
        check({name, " stall_req@issue"}, 32'(stall_req), 32'(exp_stall));
        @(posedge clk);
        #1;
        start  = 1'b0;
        md_op  = 3'd0;
        rs_val = $urandom;
        rt_val = $urandom;
    endtask

    // Counts negedges with busy high until it falls; bounded.
    task automatic count_busy(output int cnt);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
    endtask

    initial begin
        int c;
        n_checks = 0;
        n_fail   = 0;
        start    = 1'b0;
        md_op    = 3'd0;
        rs_val   = 32'd0;
        rt_val   = 32'd0;
        reset    = 1'b1;

        vecs[0]  = '{3'd1, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFE, 5,  1'b1};
        vecs[1]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE, 5,  1'b1};
        vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b1};
        vecs[3]  = '{3'd4, 32'd7,         32'd2,          32'd1,         32'd3,         10, 1'b1};
        vecs[4]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000, 10, 1'b1};
        vecs[5]  = '{3'd5, 32'h1234_5678, 32'd0,          32'h1234_5678, 32'h8000_0000, 0,  1'b0};
        vecs[6]  = '{3'd3, 32'd5,         32'd0,          32'h1234_5678, 32'h8000_0000, 10, 1'b1};
        vecs[7]  = '{3'd6, 32'h0000_DEAD, 32'd0,          32'h1234_5678, 32'h0000_DEAD, 0,  1'b0};
        vecs[8]  = '{3'd0, 32'hFFFF_0000, 32'd3,          32'h1234_5678, 32'h0000_DEAD, 0,  1'b0};
        vecs[9]  = '{3'd7, 32'hFFFF_0000, 32'd3,          32'h1234_5678, 32'h0000_DEAD, 0,  1'b0};
        vecs[10] = '{3'd1, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 5,  1'b1};
        vecs[11] = '{3'd3, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD, 10, 1'b1};
        vecs[12] = '{3'd4, 32'hFFFF_FFFF, 32'h10,         32'h0000_000F, 32'h0FFF_FFFF, 10, 1'b1};
        vecs[13] = '{3'd2, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'd0,         5,  1'b1};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset hi", hi_out, 32'd0);
        check("reset lo", lo_out, 32'd0);

        for (int v = 0; v < 14; v++) begin
            issue(vecs[v].op, vecs[v].rs, vecs[v].rt, vecs[v].stall, $sformatf("vec%0d", v));
            count_busy(c);
            check($sformatf("vec%0d busy cycles", v), 32'(c), 32'(vecs[v].cyc));
            check($sformatf("vec%0d hi", v), hi_out, vecs[v].hi);
            check($sformatf("vec%0d lo", v), lo_out, vecs[v].lo);
        end

        // MULT 3*4 with an MTLO strobe two cycles into the op; stall_req must hold through busy.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        issue(3'd1, 32'd3, 32'd4, 1'b1, "seq5");
        @(negedge clk);
        check("seq5 stall c1", 32'(stall_req), 32'd1);
        start  = 1'b1;
        md_op  = 3'd6;
        rs_val = 32'h0000_DEAD;
        @(posedge clk);
        #1 start = 1'b0;
        md_op = 3'd0;
        c = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            c++;
            check("seq5 stall during busy", 32'(stall_req), 32'd1);
        end
        check("seq5 busy cycles", 32'(c), 32'd5);
        check("seq5 hi", hi_out, 32'd0);
        check("seq5 lo", lo_out, 32'h0000_000C);
        check("seq5 stall after", 32'(stall_req), 32'd0);

        // Start held across the completion edge: MTHI must land one edge after completion.
        @(negedge clk);
        start  = 1'b1;
        md_op  = 3'd2;
        rs_val = 32'd2;
        rt_val = 32'd3;
        @(posedge clk);
        #1;
        md_op  = 3'd5;
        rs_val = 32'h0000_AAAA;
        count_busy(c);
        check("hold busy cycles", 32'(c), 32'd5);
        check("hold hi at completion", hi_out, 32'd0);
        check("hold lo at completion", lo_out, 32'd6);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("hold hi after accept", hi_out, 32'h0000_AAAA);
        check("hold lo after accept", lo_out, 32'd6);
        check("hold busy after accept", 32'(busy), 32'd0);

        // Reset in the middle of a MULT discards it.
        issue(3'd1, 32'd3, 32'd4, 1'b1, "seq6");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("seq6 busy after reset", 32'(busy), 32'd0);
        check("seq6 hi after reset", hi_out, 32'd0);
        check("seq6 lo after reset", lo_out, 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("seq6 busy later", 32'(busy), 32'd0);
        check("seq6 hi later", hi_out, 32'd0);
        check("seq6 lo later", lo_out, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
